// File: rtl/seq_shifter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shifter_pkg
//  Description : Shared constants, op/state encodings and stage helper for
//                the multicycle barrel shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_shifter_pkg;

    // Datapath width; the stage schedule below assumes exactly 32 bits.
    localparam int WIDTH   = 32;
    // Shift-amount width; one shift stage per bit.
    localparam int SHAMT_W = 5;

    // Index of the final stage (distance 1).
    localparam logic [2:0] c_stage_last = 3'(SHAMT_W - 1);

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } op_t;

    // 2'b11 is unused and steered back to ST_IDLE by the FSM.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Stage idx handles shamt bit (SHAMT_W-1-idx): largest distance first.
    function automatic logic [2:0] stage_sel(input logic [2:0] idx);
        return c_stage_last - idx;
    endfunction

endpackage : seq_shifter_pkg
`default_nettype wire

// File: rtl/seq_shifter_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shifter_if
//  Description : Request/result bundle between the operand muxes (master)
//                and the sequential shifter (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_shifter_if;
    import seq_shifter_pkg::*;

    logic               start;
    logic [1:0]         ctrl_op;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               result_ready;
    logic [WIDTH-1:0]   data_out;

    modport master (
        output start,
        output ctrl_op,
        output data_in,
        output shamt,
        input  busy,
        input  result_ready,
        input  data_out
    );

    modport slave (
        input  start,
        input  ctrl_op,
        input  data_in,
        input  shamt,
        output busy,
        output result_ready,
        output data_out
    );

endinterface : seq_shifter_if
`default_nettype wire

// File: rtl/seq_shifter_shift_stage.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shifter_shift_stage
//  Description : One combinational shift stage with a runtime distance
//                (1/2/4/8/16), op select and enable. Shifted-out bits drop.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_shifter_shift_stage
    import seq_shifter_pkg::*;
(
    input  wire [WIDTH-1:0]   i_data,
    input  wire [SHAMT_W-1:0] i_dist,
    input  wire op_t          i_op,
    input  wire               i_en,
    output logic [WIDTH-1:0]  o_data
);

    // Select the shifted word for the requested op; pass through when idle.
    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                OP_SLL:  o_data = i_data << i_dist;
                OP_SRL:  o_data = i_data >> i_dist;
                OP_SRA:  o_data = $unsigned($signed(i_data) >>> i_dist);
                default: o_data = i_data;
            endcase
        end
    end

endmodule : seq_shifter_shift_stage
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shifter
//  Description : Multicycle 32-bit shifter. Accepts an operand in IDLE, then
//                applies stages 16/8/4/2/1 (one per cycle, gated by shamt
//                bits) and presents the result with a one-cycle ready pulse.
//                Fixed 6-cycle start-to-ready latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_shifter
    import seq_shifter_pkg::*;
(
    input  wire          clock,
    input  wire          reset,
    seq_shifter_if.slave bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_idx;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_dout;
    op_t                r_op;
    logic [SHAMT_W-1:0] r_shamt;

    logic               w_accept;
    logic               w_shifting;
    logic               w_last;
    logic               w_busy;
    logic               w_ready;
    logic [2:0]         w_sel;
    logic [SHAMT_W-1:0] w_dist;
    logic               w_en;
    logic [WIDTH-1:0]   w_stage_out;

    // Stage idx uses shamt bit (SHAMT_W-1-idx) and distance 2^(SHAMT_W-1-idx).
    assign w_sel  = stage_sel(r_idx);
    assign w_dist = {{(SHAMT_W-1){1'b0}}, 1'b1} << w_sel;
    assign w_en   = r_shamt[w_sel];

    seq_shifter_shift_stage u_stage (
        .i_data (r_acc),
        .i_dist (w_dist),
        .i_op   (r_op),
        .i_en   (w_en),
        .o_data (w_stage_out)
    );

    // State register; reset aborts any operation without a ready pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus status outputs and datapath enables.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_accept    = 1'b0;
        w_shifting  = 1'b0;
        w_last      = 1'b0;
        w_busy      = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_busy     = 1'b1;
                w_shifting = 1'b1;
                if (r_idx == c_stage_last) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_ready     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture on accept, one stage per SHIFT cycle; the output
    // register is loaded only by the final stage so it holds between ops.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_acc   <= '0;
            r_dout  <= '0;
            r_op    <= OP_SLL;
            r_shamt <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_acc   <= bus.data_in;
            r_op    <= op_t'(bus.ctrl_op);
            r_shamt <= bus.shamt;
            r_idx   <= '0;
        end else if (w_shifting) begin
            r_acc <= w_stage_out;
            r_idx <= r_idx + 3'd1;
            if (w_last) begin
                r_dout <= w_stage_out;
            end
        end
    end

    assign bus.busy         = w_busy;
    assign bus.result_ready = w_ready;
    assign bus.data_out     = r_dout;

endmodule : seq_shifter
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_shifter
//  Description : Self-checking bench for seq_shifter with a result
//                scoreboard (expected value and expected ready cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shifter;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    seq_shifter_if bus ();

    seq_shifter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
        case (op)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10:   return $unsigned($signed(d) >>> sh);
            default: return d;
        endcase
    endfunction

    // Present a request at the current negedge, record expectations, then
    // drop start and scramble the operands to show they are not resampled.
    task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
        exp_t e;
        bus.start   = 1'b1;
        bus.ctrl_op = op;
        bus.data_in = d;
        bus.shamt   = sh;
        e.data = model(op, d, sh);
        e.cyc  = cyc + 6;
        sb.push_back(e);
        @(negedge clock);
        bus.start   = 1'b0;
        bus.ctrl_op = 2'($urandom_range(0, 3));
        bus.data_in = $urandom;
        bus.shamt   = 5'($urandom_range(0, 31));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy || bus.result_ready) && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check_eq("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    // Scoreboard consumer: every ready pulse must match a pending entry in
    // value and in cycle.
    always @(negedge clock) begin
        if (reset && bus.result_ready) begin
            check_eq("ready_has_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check_eq("result", bus.data_out, e.data);
                check_eq("latency", 32'(cyc), 32'(e.cyc));
                check_eq("busy_in_done", 32'(bus.busy), 32'd1);
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        bus.start   = 1'b1;
        bus.ctrl_op = 2'b00;
        bus.data_in = 32'hDEAD_BEEF;
        bus.shamt   = 5'd3;
        repeat (2) @(posedge clock);
        @(negedge clock);
        // reset overrides start
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_ready", 32'(bus.result_ready), 32'd0);
        check_eq("rst_data", bus.data_out, 32'd0);
        bus.start = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        check_eq("idle_busy", 32'(bus.busy), 32'd0);

        send(2'b00, 32'h0000_0001, 5'd31); wait_idle();
        send(2'b10, 32'h8000_0000, 5'd4);  wait_idle();
        send(2'b01, 32'h8000_0000, 5'd4);  wait_idle();
        send(2'b10, 32'hFFFF_FFF0, 5'd0);  wait_idle();
        send(2'b11, 32'h1234_5678, 5'd7);  wait_idle();

        // start held high with changing operands: only the first request
        // and the one presented once IDLE is reached may be accepted
        begin
            exp_t e;
            bus.start   = 1'b1;
            bus.ctrl_op = 2'b00;
            bus.data_in = 32'h0000_0003;
            bus.shamt   = 5'd2;
            e.data = 32'h0000_000C;
            e.cyc  = cyc + 6;
            sb.push_back(e);
            for (int k = 1; k <= 6; k++) begin
                @(negedge clock);
                bus.ctrl_op = 2'($urandom_range(0, 3));
                bus.data_in = $urandom;
                bus.shamt   = 5'($urandom_range(0, 31));
            end
            @(negedge clock);
            check_eq("idle_after_done", 32'(bus.busy), 32'd0);
            bus.ctrl_op = 2'b01;
            bus.data_in = 32'hA5A5_0000;
            bus.shamt   = 5'd16;
            e.data = 32'h0000_A5A5;
            e.cyc  = cyc + 6;
            sb.push_back(e);
            @(negedge clock);
            bus.start = 1'b0;
            wait_idle();
        end

        // reset in the middle of SHIFT: abort, no pulse afterwards
        send(2'b00, 32'h0000_0F0F, 5'd4);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_ready", 32'(bus.result_ready), 32'd0);
        check_eq("abort_data", bus.data_out, 32'd0);
        sb.delete();
        reset = 1'b1;
        repeat (10) @(negedge clock);

        // back-to-back with held result between operations
        send(2'b00, 32'h0000_00FF, 5'd8); wait_idle();
        repeat (3) @(negedge clock);
        check_eq("hold_data", bus.data_out, 32'h0000_FF00);
        send(2'b01, 32'h0000_00FF, 5'd8); wait_idle();
        check_eq("srl_final", bus.data_out, 32'h0000_0000);

        for (int i = 0; i < 8; i++) begin
            send(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
            wait_idle();
        end

        begin
            int n;
            n = 0;
            while (sb.size() != 0 && n < 20) begin
                @(negedge clock);
                n++;
            end
            check_eq("sb_drained", 32'(sb.size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_shifter
`default_nettype wire
